frv_mem_arbiter: RTL

Parametrised N-channel memory request arbiter that merges several `cen/wen/stall/error` style requester ports (core imem, dmem, accelerator or DMA masters) onto one downstream memory port of the same protocol. It sits between the core and the memory/bus bridge. It owns grant selection, grant locking while the downstream port stalls, and routing of the single-cycle response back to the channel whose request was accepted.

---
 rtl/frv_mem_arbiter_if.sv | 53 +++++
 rtl/frv_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/frv_mem_arbiter_if.sv
// frv_mem_arbiter_if: requester-side and memory-side signals of the
// N-channel memory arbiter, bundled for the arbiter's port list.
//
// Handshake (both sides): a request is accepted in any cycle where
// cen=1 and stall=0; the requester holds every request field stable
// while stalled; the response (rdata, error) is valid exactly one cycle
// after acceptance.
interface frv_mem_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int SW  = DW / 8;
  localparam int IDW = $clog2(NCH);

  logic [NCH-1:0]    req_cen;
  logic [NCH-1:0]    req_wen;
  logic [NCH*SW-1:0] req_strb;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    req_stall;
  logic [NCH-1:0]    req_error;
  logic [DW-1:0]     req_rdata;

  logic              mem_cen;
  logic              mem_wen;
  logic [SW-1:0]     mem_strb;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_stall;
  logic              mem_error;
  logic [DW-1:0]     mem_rdata;

  // Lock state of the arbiter, exposed for observation.
  logic              dbg_lock;
  logic [IDW-1:0]    dbg_lock_id;

  modport slave (
    input  req_cen, req_wen, req_strb, req_addr, req_wdata,
    output req_stall, req_error, req_rdata,
    output mem_cen, mem_wen, mem_strb, mem_addr, mem_wdata,
    input  mem_stall, mem_error, mem_rdata,
    output dbg_lock, dbg_lock_id
  );

  modport master (
    output req_cen, req_wen, req_strb, req_addr, req_wdata,
    input  req_stall, req_error, req_rdata,
    input  mem_cen, mem_wen, mem_strb, mem_addr, mem_wdata,
    output mem_stall, mem_error, mem_rdata,
    input  dbg_lock, dbg_lock_id
  );
endinterface

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: merges NCH cen/wen/stall/error requester ports onto one
// downstream memory port. Grant is locked onto a channel while the
// downstream port stalls it, and the one-cycle response is routed back to
// the channel whose request was accepted.
// Optional feature macro: FRV_MEM_ARB_RR_EN selects round-robin
// arbitration; when undefined the lowest requesting index wins.
module frv_mem_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  frv_mem_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NCH);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t    state;
  logic [IDW-1:0] lock_id;
  logic           rsp_vld;
  logic [IDW-1:0] rsp_id;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_next;
  logic           lock;
  logic           mem_cen;
  logic           accept;
  logic [NCH-1:0] stall_vec;
  logic [NCH-1:0] error_vec;

`ifdef FRV_MEM_ARB_RR_EN
  localparam logic [IDW:0] NCH_W = (IDW+1)'(NCH);
  logic [IDW-1:0] rr_ptr;
  logic [NCH-1:0] rr_req;
  logic [IDW-1:0] rr_off;
  logic [IDW:0]   rr_sum;
`endif

  assign lock = (state == ST_LOCKED);

  // Grant selection: locked channel wins outright, otherwise arbitrate.
  always_comb begin
    grant = '0;
`ifdef FRV_MEM_ARB_RR_EN
    // Rotate requests so rr_ptr sits at bit 0, find the first one, rotate back.
    rr_req = NCH'({bus.req_cen, bus.req_cen} >> rr_ptr);
    rr_off = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rr_req[k]) rr_off = IDW'(k);
    end
    rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
    if (rr_sum >= NCH_W) rr_sum = rr_sum - NCH_W;
`endif
    if (lock) begin
      grant = lock_id;
    end else begin
`ifdef FRV_MEM_ARB_RR_EN
      grant = rr_sum[IDW-1:0];
`else
      for (int k = NCH - 1; k >= 0; k--) begin
        if (bus.req_cen[k]) grant = IDW'(k);
      end
`endif
    end
  end

  // Downstream request enable; reset forces the memory port idle.
  always_comb begin
    mem_cen = 1'b0;
    if (!g_reset) begin
      mem_cen = lock ? bus.req_cen[lock_id] : (|bus.req_cen);
    end
  end

  assign accept     = mem_cen & ~bus.mem_stall;
  assign grant_next = (grant == IDW'(NCH - 1)) ? '0 : grant + IDW'(1);

  // Per-channel stall and response-error routing.
  always_comb begin
    stall_vec = '0;
    error_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      stall_vec[i] = bus.req_cen[i] & (g_reset | (grant != IDW'(i)) | bus.mem_stall);
      error_vec[i] = rsp_vld & (rsp_id == IDW'(i)) & bus.mem_error;
    end
  end

  assign bus.mem_cen     = mem_cen;
  assign bus.mem_wen     = bus.req_wen[grant];
  assign bus.mem_strb    = bus.req_strb[int'(grant)*(DW/8) +: (DW/8)];
  assign bus.mem_addr    = bus.req_addr[int'(grant)*AW +: AW];
  assign bus.mem_wdata   = bus.req_wdata[int'(grant)*DW +: DW];
  assign bus.req_stall   = stall_vec;
  assign bus.req_error   = error_vec;
  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.dbg_lock    = lock;
  assign bus.dbg_lock_id = lock_id;

  // Lock FSM: hold the grant on a stalled channel until it is accepted.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state   <= ST_OPEN;
      lock_id <= '0;
    end else begin
      case (state)
        ST_OPEN: begin
          if (mem_cen && bus.mem_stall) begin
            state   <= ST_LOCKED;
            lock_id <= grant;
          end
        end
        ST_LOCKED: begin
          if (accept) state <= ST_OPEN;
        end
        default: state <= ST_OPEN;
      endcase
    end
  end

  // Response tracking: remember which channel owns next cycle's response.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
    end else begin
      rsp_vld <= accept;
      if (accept) rsp_id <= grant;
    end
  end

`ifdef FRV_MEM_ARB_RR_EN
  // Round-robin pointer moves just past the most recently accepted channel.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) rr_ptr <= '0;
    else if (accept) rr_ptr <= grant_next;
  end
`else
  // Fixed priority keeps no pointer; the next-grant value stays unused.
  logic unused_grant_next;
  assign unused_grant_next = ^grant_next;
`endif

endmodule
